// File: rtl/sw_pkg.sv
// ----------------------------------------------------------------------------
// sw_pkg
// Shared types and helpers for the output-port arbiter and its picker.
//   state_e : arbiter FSM states (IDLE, OWN, ABORT, GAP)
//   CNT_W   : width of the frame / drop statistics counters
//   BEAT_W  : width of the per-frame beat counter used by the optional
//             frame timeout (SW_ARB_FRAME_TIMEOUT_EN)
//   onehot  : index -> one-hot vector (up to 16 ports)
// ----------------------------------------------------------------------------
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int CNT_W  = 16;
    localparam int BEAT_W = 16;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'b1 << idx;
    endfunction

endpackage

// File: rtl/sw_rr_picker.sv
// ----------------------------------------------------------------------------
// sw_rr_picker
// Purely combinational rotating-priority picker. Searches req_i starting at
// ptr_i, ascending with wrap-around, and returns the first set bit.
// Ports:
//   req_i    [N-1:0]  request vector
//   ptr_i    [IW-1:0] index holding highest priority (must be < N)
//   winner_o [IW-1:0] index of the winning request (0 when none)
//   valid_o           at least one request is set
// ----------------------------------------------------------------------------
module sw_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          valid_o
);

    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        winner_o = '0;
        valid_o  = |req_i;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                winner_o = IW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_out_port_arbiter.sv
// ----------------------------------------------------------------------------
// sw_out_port_arbiter
// Round-robin, frame-granular arbiter sharing one output FIFO write port
// between N_PORTS input frame FSMs. One frame is forwarded at a time; losing
// and waiting ports are held off through busy.
// Ports:
//   clk, rst (sync, active-high)
//   req       [N_PORTS-1:0]          per-port write request, high per beat
//   data_in   [N_PORTS*W_WIDTH-1:0]  packed per-port data byte
//   fifo_full                        output FIFO full
//   fifo_wr / fifo_data              FIFO write strobe / data (combinational)
//   busy      [N_PORTS-1:0]          per-port busy back to the input FSMs
//   grant     [N_PORTS-1:0]          one-hot owner, zero when no owner
//   frame_cnt / drop_cnt [15:0]      completed / aborted frames (wrapping)
// Optional: define SW_ARB_FRAME_TIMEOUT_EN to abort frames reaching
// MAX_BEATS beats (MAX_BEATS >= 2).
// ----------------------------------------------------------------------------
module sw_out_port_arbiter
    import sw_pkg::*;
#(
    parameter int W_WIDTH   = 8,
    parameter int N_PORTS   = 4,
    parameter int MAX_BEATS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           req,
    input  logic [N_PORTS*W_WIDTH-1:0]   data_in,
    input  logic                         fifo_full,
    output logic                         fifo_wr,
    output logic [W_WIDTH-1:0]           fifo_data,
    output logic [N_PORTS-1:0]           busy,
    output logic [N_PORTS-1:0]           grant,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic [N_PORTS-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
    logic [BEAT_W-1:0]    beat_q, beat_d;
`endif

    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [IW-1:0]        cur_idx;
    logic [IW-1:0]        next_ptr;
    logic [N_PORTS-1:0]   cur_oh;
    logic                 wr_raw;
    logic [W_WIDTH-1:0]   port_data [N_PORTS];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = data_in[gi*W_WIDTH +: W_WIDTH];
        end
    endgenerate

    sw_rr_picker #(.N(N_PORTS)) u_picker (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_vld)
    );

    // In IDLE the winner is live from the picker so the first beat is not
    // lost; afterwards the registered owner steers the mux.
    assign cur_idx  = (state_q == IDLE) ? pick_idx : owner_q;
    assign cur_oh   = N_PORTS'(onehot(4'(cur_idx)));
    assign next_ptr = (owner_q == IW'(N_PORTS - 1)) ? '0 : owner_q + 1'b1;

    assign fifo_data = port_data[cur_idx];
    assign fifo_wr   = wr_raw & ~rst;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_raw      = 1'b0;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
        beat_d      = beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    wr_raw  = ~fifo_full;
                    owner_d = pick_idx;
                    if (fifo_full) begin
                        state_d = ABORT;
                        grant_d = '0;
                        busy_d  = '1;
                    end else begin
                        state_d = OWN;
                        grant_d = cur_oh;
                        busy_d  = ~cur_oh;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
                        // Counts beats written; the IDLE beat is the first.
                        beat_d  = BEAT_W'(1);
`endif
                    end
                end
            end
            OWN: begin
                // Owner dropping req wins over fifo_full: frame is complete.
                if (!req[owner_q]) begin
                    state_d     = GAP;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    rr_ptr_d    = next_ptr;
                    grant_d     = '0;
                    busy_d      = '1;
                end else if (fifo_full) begin
                    state_d = ABORT;
                    grant_d = '0;
                    busy_d  = '1;
                end else begin
                    wr_raw = 1'b1;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
                    beat_d = beat_q + 1'b1;
                    if (beat_d >= BEAT_W'(MAX_BEATS)) begin
                        state_d = ABORT;
                        grant_d = '0;
                        busy_d  = '1;
                    end
`endif
                end
            end
            ABORT: begin
                // Hold until every port has let go so no partial frame resumes.
                if (!(|req)) begin
                    state_d    = GAP;
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    rr_ptr_d   = next_ptr;
                end
            end
            GAP: begin
                state_d = IDLE;
                busy_d  = '0;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            busy_q      <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
            beat_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef SW_ARB_FRAME_TIMEOUT_EN
            beat_q      <= beat_d;
`endif
        end
    end

endmodule

// File: doc/sw_out_port_arbiter.md
Name: sw_out_port_arbiter

Overview:
- Round-robin, frame-granular arbiter that shares one output-port FIFO write interface between N_PORTS input-side frame FSMs.
- Each input FSM presents a write request (its wr_en) plus its data byte. The arbiter forwards exactly one frame at a time to the FIFO.
- It drives per-port busy back to every input FSM so the losing and waiting ports abort or stay idle.
- Sits between the input FSMs and the output-port FIFO, one instance per output port.

Parameters:
- W_WIDTH, 8, data byte width.
- N_PORTS, 4, number of requesting input ports (2..16).
- MAX_BEATS, 64, frame length limit in beats; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_PORTS  per-port write request (input FSM wr_en); high for every payload beat of a frame.
- data_in  in  N_PORTS*W_WIDTH  packed per-port data; port i occupies bits [i*W_WIDTH +: W_WIDTH].
- fifo_full  in  1  output FIFO full.
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  W_WIDTH  FIFO write data.
- busy  out  N_PORTS  per-port busy, fed to each input FSM's port_busy.
- grant  out  N_PORTS  one-hot current owner; zero when no owner.
- frame_cnt  out  16  frames completed; wraps at 0xFFFF->0.
- drop_cnt  out  16  frames aborted; wraps.

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, rr_ptr=0, grant=0, busy=0, frame_cnt=0, drop_cnt=0. fifo_wr is 0 while rst is high.
- Selection: search req starting at rr_ptr, ascending with wrap. The first set bit is the winner w.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose w combinationally. Same cycle, fifo_wr=req[w] & ~fifo_full and fifo_data=data_in[w], so the first beat is not lost.
  - Next state is OWN; grant<=onehot(w); busy<=~onehot(w).
  - If fifo_full in the first cycle, go to ABORT instead of OWN.
- OWN:
  - fifo_wr = req[w] & ~fifo_full; fifo_data = data_in[w], combinational mux; zero latency.
  - Non-owner req is ignored; those ports see busy=1 and abort.
  - req[w] falling to 0 is end of frame: go to GAP, frame_cnt++, rr_ptr<=(w+1) mod N_PORTS.
  - fifo_full while req[w]=1: no write. Go to ABORT; busy[w]<=1 so the owner FSM drops to idle.
- ABORT:
  - busy all-ones, grant=0, fifo_wr=0.
  - Stay while any req is high, so a partial frame is never resumed.
  - When req is all zero, go to GAP, drop_cnt++, rr_ptr<=(w+1) mod N_PORTS.
- GAP:
  - One cycle; busy=all-ones, grant=0, fifo_wr=0.
  - Guarantees the winner's FSM returns through its end-of-frame handling before new arbitration.
  - Next state is IDLE with busy<=0.
- Simultaneous events:
  - Owner req drop coincident with fifo_full counts as a completed frame.
  - Counters never saturate; they wrap.
- Reset mid-frame: all state clears at that edge. A frame in flight is neither counted nor written.
- fifo_wr is never high when fifo_full is high.

Optional Feature:
- Macro: SW_ARB_FRAME_TIMEOUT_EN.
- With the macro:
  - OWN keeps an 8..16-bit beat counter, cleared on entry.
  - On reaching MAX_BEATS with req[w] still high, go to ABORT and increment drop_cnt per ABORT rules.
  - The beat that reaches MAX_BEATS is still written.
- Without the macro: no counter; frames are unbounded.

Decomposition:
- Package sw_pkg:
  - State enum: IDLE, OWN, ABORT, GAP.
  - Counter width constant CNT_W=16.
  - Function onehot(idx).
- Sub-module sw_rr_picker (req, ptr -> winner index, valid): purely combinational priority rotate, reusable by other arbiters.

Test Plan:
- Single port: req[2] high 5 beats with data 0x10..0x14, rr_ptr=0 -> 5 fifo_wr pulses with the same data in order, grant=0100, busy=1011 from cycle 2, frame_cnt=1, rr_ptr=3.
- Contention: req[0] and req[3] rise together, rr_ptr=3 -> port 3 wins, busy[0]=1 next cycle, only port-3 bytes written, then rr_ptr=0.
- Fairness: all four ports request back-to-back frames of 3 beats -> grant order 0,1,2,3,0, with one GAP cycle between frames.
- FIFO full: fifo_full asserted on beat 3 of 6 -> exactly 2 writes, state goes to ABORT, drop_cnt=1, no write after full.
- Reset during OWN: rst high on beat 2 -> next cycle grant=0, busy=0, counters 0, fifo_wr=0.
- Timeout (SW_ARB_FRAME_TIMEOUT_EN, MAX_BEATS=4): 10-beat frame -> 4 writes, drop_cnt=1. Without the macro -> 10 writes, frame_cnt=1.
